lsq_dcache_responder: RTL and testbench
=======================================

Name: lsq_dcache_responder

Overview:
Data-side memory responder serving the LSQ's BUS_COMMAND requests. It owns a direct-mapped, write-through, no-write-allocate data cache and a small miss-status table (MSHR). Load hits return data in the same cycle. Load misses and all stores are forwarded to the tagged main-memory interface. Returning fill tags are matched, the cache is filled, and the data is replayed to the LSQ on the tag bus.

Parameters:
NUM_LINES, 32, cache lines of 64 bits each; power of 2.
MSHR_SIZE, 4, outstanding load misses.
MEM_ADDR_BITS, 16, significant byte-address bits; upper address bits are ignored.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
lsq2Dcache_command  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
mem_address_out  in  64  LSQ byte address, 8-byte aligned
mem_data_out  in  64  LSQ store data
mem_response_in  out  5  nonzero = request accepted, value = memory tag; 0 = rejected/hit/idle
mem_tag_in  out  5  nonzero = miss data valid this cycle, for this tag
mem_data_in  out  64  hit data (cache_hit=1) or fill data (mem_tag_in!=0)
cache_hit  out  1  load hit this cycle
proc2Dmem_command  out  2  command to main memory
proc2Dmem_addr  out  64  address to main memory
proc2Dmem_data  out  64  store data to main memory
Dmem2proc_response  in  5  memory acceptance tag; 0 = busy
Dmem2proc_tag  in  5  completed-load tag; 0 = none
Dmem2proc_data  in  64  data for Dmem2proc_tag

Behaviour:
- Address split: idx = addr[3+log2(NUM_LINES)-1:3]; tag = addr[MEM_ADDR_BITS-1:3+log2(NUM_LINES)].
- Per-line state: valid, tag, data. Per-MSHR-entry state: valid, mem_tag, idx, line tag, no_fill.
- Reset (reset=0, asynchronous): all lines invalid, all MSHR entries invalid. While reset is low, every output is forced to 0 (commands are BUS_NONE).
- Load hit (valid && tag match): cache_hit=1 and mem_data_in=line data, both combinational in the same cycle. mem_response_in=0. No memory request is issued.
- Load miss with a free MSHR entry: proc2Dmem_command=BUS_LOAD; address is passed through; mem_response_in=Dmem2proc_response (combinational). If the response is nonzero, the lowest free MSHR entry is allocated at the clock edge. If the response is 0, nothing is allocated and the LSQ retries.
- Load miss with the MSHR full: no memory command is issued; mem_response_in=0; cache_hit=0.
- Store: always forwarded (BUS_STORE, address, data); mem_response_in=Dmem2proc_response.
  - If accepted and the line hits, the line data is updated at the edge.
  - If the line misses, the cache is unchanged.
  - Accepted stores set no_fill on every valid MSHR entry with the same idx and tag. This prevents a stale fill from overwriting newer store data.
  - Stores never produce a later mem_tag_in.
- Fill: Dmem2proc_tag!=0 and it matches a valid MSHR entry.
  - Combinationally: mem_tag_in=Dmem2proc_tag and mem_data_in=Dmem2proc_data.
  - At the edge: the entry is freed. Unless no_fill is set, the line is written (valid, tag, data).
  - A nonzero Dmem2proc_tag that matches no entry (i.e. a store completion) is ignored; mem_tag_in stays 0.
- mem_data_in mux: a fill takes priority over a hit for the data bus. If a fill and a load hit occur in the same cycle, the hit is suppressed: cache_hit=0, the load is treated as rejected (mem_response_in=0, no memory command), and the LSQ retries.
- Simultaneous fill, and a new load miss to the same idx, in the same cycle: the fill writes the line, and the miss is still issued normally. A freed entry can be reallocated in the same cycle it is freed.
- Simultaneous accepted store and fill to the same line: the store's data wins in the array; the fill is still reported to the LSQ.
- Lookups use pre-edge array contents. There is no same-cycle bypass from a fill to a lookup.
- Latency: hit 0 cycles; miss is memory latency plus 0 cycles after the tag returns.

Test Plan:
- Reset, then BUS_LOAD to 0x100 with Dmem2proc_response=3 -> cache_hit=0, mem_response_in=3, proc2Dmem_command=BUS_LOAD, proc2Dmem_addr=0x100. Later Dmem2proc_tag=3 with data 0xDEAD -> mem_tag_in=3, mem_data_in=0xDEAD.
- Repeat BUS_LOAD to 0x100 -> cache_hit=1, mem_data_in=0xDEAD, mem_response_in=0, proc2Dmem_command=BUS_NONE.
- BUS_STORE to 0x100 with data 0xBEEF, accepted with response 5 -> forwarded to memory. The next load of 0x100 hits with 0xBEEF. A later Dmem2proc_tag=5 -> mem_tag_in=0.
- Issue 4 misses (0x200, 0x300, 0x400, 0x500) accepted with tags 1, 2, 4, 6; a 5th miss to 0x600 -> mem_response_in=0, proc2Dmem_command=BUS_NONE. Returning tag 2 frees an entry, and the retried load of 0x600 is accepted.
- Load miss 0x700 (tag 7), then store 0x700=0x11 before tag 7 returns; tag 7 returns with 0x99 -> mem_data_in=0x99 to the LSQ. The next load of 0x700 misses (the line was not filled).
- Assert reset mid-miss (MSHR holding tag 3), release, and return tag 3 -> mem_tag_in=0. A load of a previously cached address misses.

Source files
------------

// File: rtl/lsq_dcache_responder.sv
// rtl/lsq_dcache_responder.sv - LSQ data-side responder: direct-mapped write-through cache with MSHR
// Load hits answer combinationally; load misses and stores go to tagged memory, fills replay on the tag bus.
module lsq_dcache_responder #(
    parameter int NUM_LINES     = 32,
    parameter int MSHR_SIZE     = 4,
    parameter int MEM_ADDR_BITS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  lsq2Dcache_command,
    input  logic [63:0] mem_address_out,
    input  logic [63:0] mem_data_out,
    output logic [4:0]  mem_response_in,
    output logic [4:0]  mem_tag_in,
    output logic [63:0] mem_data_in,
    output logic        cache_hit,
    output logic [1:0]  proc2Dmem_command,
    output logic [63:0] proc2Dmem_addr,
    output logic [63:0] proc2Dmem_data,
    input  logic [4:0]  Dmem2proc_response,
    input  logic [4:0]  Dmem2proc_tag,
    input  logic [63:0] Dmem2proc_data
);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS  = MEM_ADDR_BITS - 3 - IDX_BITS;
    localparam int MSHR_BITS = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic                line_valid [NUM_LINES];
    logic [TAG_BITS-1:0] line_tag   [NUM_LINES];
    logic [63:0]         line_data  [NUM_LINES];

    logic                mshr_valid   [MSHR_SIZE];
    logic                mshr_no_fill [MSHR_SIZE];
    logic [4:0]          mshr_mem_tag [MSHR_SIZE];
    logic [IDX_BITS-1:0] mshr_idx     [MSHR_SIZE];
    logic [TAG_BITS-1:0] mshr_ltag    [MSHR_SIZE];

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic                 line_hit;
    logic                 fill_valid;
    logic [MSHR_BITS-1:0] fill_sel;
    logic                 alloc_avail;
    logic [MSHR_BITS-1:0] alloc_sel;
    logic                 is_load;
    logic                 is_store;
    logic                 load_hit;
    logic                 load_issue;
    logic                 load_alloc;
    logic                 store_acc;
    logic                 fill_write;
    logic                 store_write;

    assign req_idx  = mem_address_out[3+IDX_BITS-1:3];
    assign req_tag  = mem_address_out[MEM_ADDR_BITS-1:3+IDX_BITS];
    assign line_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    always_comb begin
        fill_valid = 1'b0;
        fill_sel   = '0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            if (!fill_valid && mshr_valid[i] && (Dmem2proc_tag != 5'd0) &&
                (mshr_mem_tag[i] == Dmem2proc_tag)) begin
                fill_valid = 1'b1;
                fill_sel   = MSHR_BITS'(i);
            end
        end
    end

    // An entry being freed by this cycle's fill is available for reallocation.
    always_comb begin
        alloc_avail = 1'b0;
        alloc_sel   = '0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            if (!alloc_avail &&
                (!mshr_valid[i] || (fill_valid && (fill_sel == MSHR_BITS'(i))))) begin
                alloc_avail = 1'b1;
                alloc_sel   = MSHR_BITS'(i);
            end
        end
    end

    assign is_load    = reset && (lsq2Dcache_command == BUS_LOAD);
    assign is_store   = reset && (lsq2Dcache_command == BUS_STORE);
    assign load_hit   = is_load && line_hit && !fill_valid;
    assign load_issue = is_load && !line_hit && alloc_avail;
    assign load_alloc = load_issue && (Dmem2proc_response != 5'd0);
    assign store_acc  = is_store && (Dmem2proc_response != 5'd0);
    assign fill_write = reset && fill_valid && !mshr_no_fill[fill_sel];

    // A store must land on the line as it will exist after this edge's fill.
    always_comb begin
        store_write = 1'b0;
        if (store_acc) begin
            if (fill_write && (mshr_idx[fill_sel] == req_idx))
                store_write = (mshr_ltag[fill_sel] == req_tag);
            else
                store_write = line_hit;
        end
    end

    always_comb begin
        mem_response_in   = 5'd0;
        mem_tag_in        = 5'd0;
        mem_data_in       = 64'd0;
        cache_hit         = 1'b0;
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = 64'd0;
        proc2Dmem_data    = 64'd0;
        if (reset) begin
            if (fill_valid) begin
                mem_tag_in  = Dmem2proc_tag;
                mem_data_in = Dmem2proc_data;
            end else if (load_hit) begin
                mem_data_in = line_data[req_idx];
            end
            cache_hit = load_hit;
            if (load_issue) begin
                proc2Dmem_command = BUS_LOAD;
                proc2Dmem_addr    = mem_address_out;
                mem_response_in   = Dmem2proc_response;
            end else if (is_store) begin
                proc2Dmem_command = BUS_STORE;
                proc2Dmem_addr    = mem_address_out;
                proc2Dmem_data    = mem_data_out;
                mem_response_in   = Dmem2proc_response;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) line_valid[i] <= 1'b0;
            for (int i = 0; i < MSHR_SIZE; i++) begin
                mshr_valid[i]   <= 1'b0;
                mshr_no_fill[i] <= 1'b0;
            end
        end else begin
            if (fill_valid) begin
                mshr_valid[fill_sel] <= 1'b0;
                if (fill_write) line_valid[mshr_idx[fill_sel]] <= 1'b1;
            end
            if (store_acc) begin
                for (int i = 0; i < MSHR_SIZE; i++) begin
                    if (mshr_valid[i] && (mshr_idx[i] == req_idx) && (mshr_ltag[i] == req_tag))
                        mshr_no_fill[i] <= 1'b1;
                end
            end
            if (load_alloc) begin
                mshr_valid[alloc_sel]   <= 1'b1;
                mshr_no_fill[alloc_sel] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fill_write) begin
            line_tag[mshr_idx[fill_sel]]  <= mshr_ltag[fill_sel];
            line_data[mshr_idx[fill_sel]] <= Dmem2proc_data;
        end
        if (store_write) line_data[req_idx] <= mem_data_out;
        if (load_alloc) begin
            mshr_mem_tag[alloc_sel] <= Dmem2proc_response;
            mshr_idx[alloc_sel]     <= req_idx;
            mshr_ltag[alloc_sel]    <= req_tag;
        end
    end
endmodule

// File: tb/tb_lsq_dcache_responder.sv
// tb/tb_lsq_dcache_responder.sv - directed vector table plus randomized run against a cache/MSHR model
module tb_lsq_dcache_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  lsq2Dcache_command = 2'd0;
    logic [63:0] mem_address_out = 64'd0;
    logic [63:0] mem_data_out = 64'd0;
    logic [4:0]  mem_response_in;
    logic [4:0]  mem_tag_in;
    logic [63:0] mem_data_in;
    logic        cache_hit;
    logic [1:0]  proc2Dmem_command;
    logic [63:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [4:0]  Dmem2proc_response = 5'd0;
    logic [4:0]  Dmem2proc_tag = 5'd0;
    logic [63:0] Dmem2proc_data = 64'd0;

    int checks = 0;
    int failures = 0;

    lsq_dcache_responder dut (
        .clock(clock), .reset(reset),
        .lsq2Dcache_command(lsq2Dcache_command),
        .mem_address_out(mem_address_out), .mem_data_out(mem_data_out),
        .mem_response_in(mem_response_in), .mem_tag_in(mem_tag_in),
        .mem_data_in(mem_data_in), .cache_hit(cache_hit),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_tag(Dmem2proc_tag),
        .Dmem2proc_data(Dmem2proc_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  resp;
        logic [4:0]  dtag;
        logic [63:0] ddata;
        logic [4:0]  e_resp;
        logic [4:0]  e_tag;
        logic        e_hit;
        logic [1:0]  e_cmd;
        logic        chk_data;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [4:0] mt;
        int         idx;
        logic [7:0] lt;
        bit         nf;
    } miss_t;

    bit          m_valid[32];
    logic [7:0]  m_tag[32];
    logic [63:0] m_data[32];
    miss_t       mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] c, input logic [63:0] a, input logic [63:0] w,
                       input logic [4:0] r, input logic [4:0] dt, input logic [63:0] dd,
                       input logic [4:0] er, input logic [4:0] et, input logic eh,
                       input logic [1:0] ec, input logic cd, input logic [63:0] ed);
        vec_t v;
        v.cmd = c; v.addr = a; v.wdata = w; v.resp = r; v.dtag = dt; v.ddata = dd;
        v.e_resp = er; v.e_tag = et; v.e_hit = eh; v.e_cmd = ec; v.chk_data = cd; v.e_data = ed;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [1:0] c, input logic [63:0] a, input logic [63:0] w,
                         input logic [4:0] r, input logic [4:0] dt, input logic [63:0] dd);
        lsq2Dcache_command = c; mem_address_out = a; mem_data_out = w;
        Dmem2proc_response = r; Dmem2proc_tag = dt; Dmem2proc_data = dd;
    endtask

    task automatic compare(input string tagname, input logic [63:0] a, input logic [63:0] w,
                           input logic [4:0] er, input logic [4:0] et, input logic eh,
                           input logic [1:0] ec, input logic cd, input logic [63:0] ed);
        chk({tagname, ".mem_response_in"}, 64'(mem_response_in), 64'(er));
        chk({tagname, ".mem_tag_in"}, 64'(mem_tag_in), 64'(et));
        chk({tagname, ".cache_hit"}, 64'(cache_hit), 64'(eh));
        chk({tagname, ".proc2Dmem_command"}, 64'(proc2Dmem_command), 64'(ec));
        if (ec != 2'd0) chk({tagname, ".proc2Dmem_addr"}, proc2Dmem_addr, a);
        if (ec == 2'd2) chk({tagname, ".proc2Dmem_data"}, proc2Dmem_data, w);
        if (cd) chk({tagname, ".mem_data_in"}, mem_data_in, ed);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        drive(v.cmd, v.addr, v.wdata, v.resp, v.dtag, v.ddata);
        @(negedge clock);
        compare(name, v.addr, v.wdata, v.e_resp, v.e_tag, v.e_hit, v.e_cmd, v.chk_data, v.e_data);
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".mem_response_in"}, 64'(mem_response_in), 64'd0);
        chk({name, ".mem_tag_in"}, 64'(mem_tag_in), 64'd0);
        chk({name, ".mem_data_in"}, mem_data_in, 64'd0);
        chk({name, ".cache_hit"}, 64'(cache_hit), 64'd0);
        chk({name, ".proc2Dmem_command"}, 64'(proc2Dmem_command), 64'd0);
        chk({name, ".proc2Dmem_addr"}, proc2Dmem_addr, 64'd0);
        chk({name, ".proc2Dmem_data"}, proc2Dmem_data, 64'd0);
    endtask

    function automatic bit tag_outstanding(input logic [4:0] t);
        foreach (mq[i]) if (mq[i].mt == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] pick_free_tag();
        logic [4:0] t;
        do t = 5'($urandom_range(1, 31)); while (tag_outstanding(t));
        return t;
    endfunction

    task automatic random_cycle(input int n);
        logic [1:0]  c;
        logic [63:0] a, w, dd;
        logic [4:0]  r, dt;
        int          ix, fi;
        logic [7:0]  tg;
        bit          hit, issue, e_hit;
        logic [1:0]  e_cmd;
        logic [4:0]  e_resp, e_tag;
        miss_t       e, nm;
        c  = 2'($urandom_range(0, 2));
        ix = $urandom_range(0, 3);
        tg = 8'($urandom_range(0, 2));
        a  = {32'($urandom), 16'($urandom), tg, 5'(ix), 3'b000};
        w  = {32'($urandom), 32'($urandom)};
        dd = {32'($urandom), 32'($urandom)};
        r  = ($urandom_range(0, 3) == 0) ? 5'd0 : pick_free_tag();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: dt = 5'd0;
            5, 6, 7:       dt = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].mt : 5'd0;
            default:       dt = pick_free_tag();
        endcase
        drive(c, a, w, r, dt, dd);
        @(negedge clock);
        fi = -1;
        foreach (mq[i]) if (fi < 0 && dt != 5'd0 && mq[i].mt == dt) fi = i;
        hit    = m_valid[ix] && m_tag[ix] == tg;
        e_hit  = (c == 2'd1) && hit && fi < 0;
        issue  = (c == 2'd1) && !hit && (mq.size() < 4 || fi >= 0);
        e_cmd  = issue ? 2'd1 : (c == 2'd2) ? 2'd2 : 2'd0;
        e_resp = (issue || c == 2'd2) ? r : 5'd0;
        e_tag  = (fi >= 0) ? dt : 5'd0;
        compare($sformatf("rand%0d", n), a, w, e_resp, e_tag, e_hit, e_cmd,
                (fi >= 0) || e_hit, (fi >= 0) ? dd : m_data[ix]);
        if (fi >= 0) begin
            e = mq[fi];
            mq.delete(fi);
            if (!e.nf) begin
                m_valid[e.idx] = 1'b1;
                m_tag[e.idx]   = e.lt;
                m_data[e.idx]  = dd;
            end
        end
        if (c == 2'd2 && r != 5'd0) begin
            foreach (mq[i]) if (mq[i].idx == ix && mq[i].lt == tg) mq[i].nf = 1'b1;
            if (m_valid[ix] && m_tag[ix] == tg) m_data[ix] = w;
        end
        if (issue && r != 5'd0) begin
            nm.mt = r; nm.idx = ix; nm.lt = tg; nm.nf = 1'b0;
            mq.push_back(nm);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        // Idle-looking inputs are non-idle here so forced-zero outputs are meaningful.
        reset = 1'b0;
        drive(2'd1, 64'h100, 64'h5, 5'd3, 5'd3, 64'h77);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;

        //   cmd    addr    wdata   resp  dtag  ddata    e_resp e_tag hit e_cmd chk e_data
        add(2'd1, 64'h100, 64'h0,  5'd3,  5'd0, 64'h0,    5'd3,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd3, 64'hDEAD, 5'd0,  5'd3, 0, 2'd0, 1, 64'hDEAD);
        add(2'd1, 64'h100, 64'h0,  5'd9,  5'd0, 64'h0,    5'd0,  5'd0, 1, 2'd0, 1, 64'hDEAD);
        add(2'd2, 64'h100, 64'hBEEF, 5'd5, 5'd0, 64'h0,   5'd5,  5'd0, 0, 2'd2, 0, 64'h0);
        add(2'd1, 64'h100, 64'h0,  5'd0,  5'd0, 64'h0,    5'd0,  5'd0, 1, 2'd0, 1, 64'hBEEF);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd5, 64'h1234, 5'd0,  5'd0, 0, 2'd0, 0, 64'h0);
        add(2'd1, 64'h200, 64'h0,  5'd1,  5'd0, 64'h0,    5'd1,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd1, 64'h300, 64'h0,  5'd2,  5'd0, 64'h0,    5'd2,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd1, 64'h400, 64'h0,  5'd4,  5'd0, 64'h0,    5'd4,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd1, 64'h500, 64'h0,  5'd6,  5'd0, 64'h0,    5'd6,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd1, 64'h600, 64'h0,  5'd7,  5'd0, 64'h0,    5'd0,  5'd0, 0, 2'd0, 0, 64'h0);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd2, 64'h3333, 5'd0,  5'd2, 0, 2'd0, 1, 64'h3333);
        add(2'd1, 64'h600, 64'h0,  5'd7,  5'd0, 64'h0,    5'd7,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd1, 64'h1111, 5'd0,  5'd1, 0, 2'd0, 1, 64'h1111);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd4, 64'h4444, 5'd0,  5'd4, 0, 2'd0, 1, 64'h4444);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd6, 64'h5555, 5'd0,  5'd6, 0, 2'd0, 1, 64'h5555);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd7, 64'h6666, 5'd0,  5'd7, 0, 2'd0, 1, 64'h6666);
        add(2'd1, 64'h700, 64'h0,  5'd7,  5'd0, 64'h0,    5'd7,  5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd2, 64'h700, 64'h11, 5'd8,  5'd0, 64'h0,    5'd8,  5'd0, 0, 2'd2, 0, 64'h0);
        add(2'd0, 64'h0,   64'h0,  5'd0,  5'd7, 64'h99,   5'd0,  5'd7, 0, 2'd0, 1, 64'h99);
        add(2'd1, 64'h700, 64'h0,  5'd10, 5'd0, 64'h0,    5'd10, 5'd0, 0, 2'd1, 0, 64'h0);
        add(2'd1, 64'h600, 64'h0,  5'd0,  5'd0, 64'h0,    5'd0,  5'd0, 1, 2'd0, 1, 64'h6666);
        add(2'd1, 64'h600, 64'h0,  5'd11, 5'd10, 64'hAA,  5'd0,  5'd10, 0, 2'd0, 1, 64'hAA);
        add(2'd1, 64'h700, 64'h0,  5'd0,  5'd0, 64'h0,    5'd0,  5'd0, 1, 2'd0, 1, 64'hAA);
        add(2'd1, 64'h800, 64'h0,  5'd3,  5'd0, 64'h0,    5'd3,  5'd0, 0, 2'd1, 0, 64'h0);
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while the miss for tag 3 is outstanding; the late return must be dropped.
        reset = 1'b0;
        drive(2'd1, 64'h800, 64'h0, 5'd3, 5'd3, 64'h33);
        @(negedge clock);
        check_all_zero("midreset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        v = '{2'd0, 64'h0, 64'h0, 5'd0, 5'd3, 64'h33, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 64'h0};
        apply_vec(v, "stale_tag");
        v = '{2'd1, 64'h700, 64'h0, 5'd12, 5'd0, 64'h0, 5'd12, 5'd0, 1'b0, 2'd1, 1'b0, 64'h0};
        apply_vec(v, "post_reset_miss");

        reset = 1'b0;
        drive(2'd0, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        mq.delete();
        for (int n = 0; n < 3000; n++) random_cycle(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
